da_seq_ctrl: RTL and testbench

Bit-serial sequencer for a 4-tap distributed-arithmetic inner product y = sum h_i*x_i. It holds a software-programmed 16-entry partial-sum LUT and captures four signed samples through a valid/ready handshake. It walks the sample bits MSB-first, doing one LUT read and shift-accumulate per cycle. The result is presented on a valid/ready output. It sits between the sample source and the DA output consumer and owns LUT configuration.

---
 rtl/da_seq_ctrl_if.sv | 39 +++
 rtl/da_seq_ctrl.sv | 115 +++++++++++
 tb/tb_da_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/da_seq_ctrl_if.sv
// Sample / result / LUT-configuration bundle for the distributed-arithmetic
// sequencer.
//   master : sample source, result consumer and LUT programmer side
//   slave  : the sequencer (da_seq_ctrl)
// Signals:
//   in_valid_80 / in_ready_80 / x_in_80      sample-set handshake and packed taps
//   y_out_80 / out_valid_80 / out_ready_80   result handshake
//   cfg_we_80 / cfg_addr_80 / cfg_data_80    LUT write port
//   cfg_err_80                               dropped-write pulse
//   busy_80                                  sequencer not idle
interface da_seq_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int LUT_W  = 6,
    parameter int OUT_W  = LUT_W + DATA_W
);
    logic                  in_valid_80;
    logic                  in_ready_80;
    logic [4*DATA_W-1:0]   x_in_80;
    logic [OUT_W-1:0]      y_out_80;
    logic                  out_valid_80;
    logic                  out_ready_80;
    logic                  cfg_we_80;
    logic [3:0]            cfg_addr_80;
    logic [LUT_W-1:0]      cfg_data_80;
    logic                  cfg_err_80;
    logic                  busy_80;

    modport master (
        output in_valid_80, x_in_80, out_ready_80,
        output cfg_we_80, cfg_addr_80, cfg_data_80,
        input  in_ready_80, y_out_80, out_valid_80, cfg_err_80, busy_80
    );

    modport slave (
        input  in_valid_80, x_in_80, out_ready_80,
        input  cfg_we_80, cfg_addr_80, cfg_data_80,
        output in_ready_80, y_out_80, out_valid_80, cfg_err_80, busy_80
    );
endinterface

// File: rtl/da_seq_ctrl.sv
// Bit-serial sequencer for a 4-tap distributed-arithmetic inner product.
// A 16-entry LUT holds partial sums of the coefficients; each RUN cycle reads
// the entry addressed by one bit-slice of the four samples (MSB first) and
// shift-accumulates it. The MSB slice carries negative weight (two's
// complement samples).
// Ports:
//   clk_80   rising-edge clock
//   rst_80   synchronous active-high reset
//   io       da_seq_ctrl_if.slave (sample, result, LUT config, status)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting samples and LUT writes
// RUN   | one LUT read + shift-accumulate per cycle, k counts down to 0
// DONE  | result held on y_out_80 / out_valid_80 until out_ready_80
module da_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int LUT_W  = 6,
    parameter int OUT_W  = LUT_W + DATA_W
) (
    input  logic           clk_80,
    input  logic           rst_80,
    da_seq_ctrl_if.slave   io
);
    localparam int K_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [K_W-1:0] K_TOP = K_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [LUT_W-1:0]    lut [16];
    logic [DATA_W-1:0]   x_tap [4];
    logic [DATA_W-1:0]   x_in_tap [4];
    logic [K_W-1:0]      k;
    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    y_reg;
    logic                out_valid_r;
    logic                cfg_err_r;

    logic [3:0]          rd_addr;
    logic [LUT_W-1:0]    rd_word;
    logic [OUT_W-1:0]    lut_sext;
    logic [OUT_W-1:0]    acc_next;

    for (genvar i = 0; i < 4; i++) begin : g_tap
        assign x_in_tap[i] = io.x_in_80[i*DATA_W +: DATA_W];
        assign rd_addr[i]  = x_tap[i][k];
    end

    always_comb begin
        rd_word  = lut[rd_addr];
        lut_sext = {{(OUT_W-LUT_W){rd_word[LUT_W-1]}}, rd_word};
        // First slice is the sample sign bit, so it enters negated.
        if (k == K_TOP) begin
            acc_next = '0 - lut_sext;
        end else begin
            acc_next = {acc[OUT_W-2:0], 1'b0} + lut_sext;
        end
    end

    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            state       <= IDLE;
            for (int i = 0; i < 16; i++) lut[i] <= '0;
            for (int i = 0; i < 4; i++) x_tap[i] <= '0;
            k           <= '0;
            acc         <= '0;
            y_reg       <= '0;
            out_valid_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r <= io.cfg_we_80 && (state != IDLE);
            case (state)
                IDLE: begin
                    // The write lands before RUN's first read, so an entry
                    // written alongside an accept is used by that run.
                    if (io.cfg_we_80) lut[io.cfg_addr_80] <= io.cfg_data_80;
                    if (io.in_valid_80) begin
                        x_tap <= x_in_tap;
                        k     <= K_TOP;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        y_reg       <= acc_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready_80) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready_80  = (state == IDLE) && !rst_80;
    assign io.busy_80      = (state != IDLE);
    assign io.y_out_80     = y_reg;
    assign io.out_valid_80 = out_valid_r;
    assign io.cfg_err_80   = cfg_err_r;
endmodule

// File: tb/tb_da_seq_ctrl.sv
module tb_da_seq_ctrl;
    localparam int DATA_W = 4;
    localparam int LUT_W  = 6;

    logic clk_80 = 1'b0;
    logic rst_80;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lut_m [16];
    int   h [4];

    always #5 clk_80 = ~clk_80;

    da_seq_ctrl_if #(.DATA_W(DATA_W), .LUT_W(LUT_W)) bus ();

    da_seq_ctrl #(.DATA_W(DATA_W), .LUT_W(LUT_W)) dut (
        .clk_80 (clk_80),
        .rst_80 (rst_80),
        .io     (bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tap_val(input logic [15:0] x, input int i);
        int v;
        v = int'(x[i*DATA_W +: DATA_W]);
        if (v >= (1 << (DATA_W-1))) v -= (1 << DATA_W);
        return v;
    endfunction

    // Weighted sum of LUT entries over bit-slices; MSB slice weight is negative.
    function automatic int da_model(input logic [15:0] x);
        int acc, a, w;
        acc = 0;
        for (int kk = 0; kk < DATA_W; kk++) begin
            a = 0;
            for (int i = 0; i < 4; i++) if (x[i*DATA_W + kk]) a += (1 << i);
            w = (kk == DATA_W-1) ? -(1 << kk) : (1 << kk);
            acc += w * lut_m[a];
        end
        return acc;
    endfunction

    function automatic int inner_prod(input logic [15:0] x);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += h[i] * tap_val(x, i);
        return s;
    endfunction

    function automatic logic [15:0] pack(input int x0, input int x1, input int x2, input int x3);
        logic [15:0] p;
        p[3:0]   = x0[3:0];
        p[7:4]   = x1[3:0];
        p[11:8]  = x2[3:0];
        p[15:12] = x3[3:0];
        return p;
    endfunction

    function automatic int y_now();
        return int'($signed(bus.y_out_80));
    endfunction

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we_80   = 1'b1;
        bus.cfg_addr_80 = addr[3:0];
        bus.cfg_data_80 = data[LUT_W-1:0];
        @(posedge clk_80); #1;
        bus.cfg_we_80 = 1'b0;
        lut_m[addr] = data;
        chk("cfg_err_idle", bus.cfg_err_80, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid_80 && n < 20) begin
            @(posedge clk_80); #1;
            n++;
        end
    endtask

    task automatic run_sample(input logic [15:0] x, input bit wr, input int waddr,
                              input int wdata, input int hold, output int y_got);
        int n, exp_y;
        bus.in_valid_80 = 1'b1;
        bus.x_in_80     = x;
        if (wr) begin
            bus.cfg_we_80   = 1'b1;
            bus.cfg_addr_80 = waddr[3:0];
            bus.cfg_data_80 = wdata[LUT_W-1:0];
            lut_m[waddr]    = wdata;
        end
        exp_y = da_model(x);
        @(posedge clk_80); #1;
        bus.in_valid_80 = 1'b0;
        bus.cfg_we_80   = 1'b0;
        bus.x_in_80     = 16'($urandom);
        chk("accept_busy", bus.busy_80, 1);
        chk("accept_in_ready", bus.in_ready_80, 0);
        wait_valid(n);
        chk("latency", n, DATA_W);
        y_got = y_now();
        chk("y_model", y_got, exp_y);
        repeat (hold) begin
            @(posedge clk_80); #1;
            chk("hold_valid", bus.out_valid_80, 1);
            chk("hold_y", y_now(), exp_y);
        end
        bus.out_ready_80 = 1'b1;
        @(posedge clk_80); #1;
        bus.out_ready_80 = 1'b0;
        chk("release_in_ready", bus.in_ready_80, 1);
        chk("release_valid", bus.out_valid_80, 0);
        chk("release_y_kept", y_now(), exp_y);
    endtask

    initial begin
        int y, n, a, d;
        logic [15:0] x;

        rst_80           = 1'b1;
        bus.in_valid_80  = 1'b0;
        bus.x_in_80      = '0;
        bus.out_ready_80 = 1'b0;
        bus.cfg_we_80    = 1'b0;
        bus.cfg_addr_80  = '0;
        bus.cfg_data_80  = '0;
        for (int i = 0; i < 16; i++) lut_m[i] = 0;
        h[0] = 1; h[1] = 2; h[2] = 3; h[3] = -1;

        repeat (2) @(posedge clk_80);
        #1;
        chk("rst_in_ready_low", bus.in_ready_80, 0);
        rst_80 = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready_80, 1);
        chk("rst_out_valid", bus.out_valid_80, 0);
        chk("rst_y", y_now(), 0);
        chk("rst_busy", bus.busy_80, 0);
        chk("rst_cfg_err", bus.cfg_err_80, 0);

        run_sample(16'hFFFF, 0, 0, 0, 0, y);
        chk("zero_lut_y", y, 0);

        // LUT for h = {1,2,3,-1}
        for (int aa = 0; aa < 16; aa++) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (aa[i]) d += h[i];
            cfg_write(aa, d);
        end

        x = pack(1, 1, 1, 1);
        run_sample(x, 0, 0, 0, 0, y);
        chk("ones_y", y, 5);
        x = pack(7, -8, 3, 2);
        run_sample(x, 0, 0, 0, 1, y);
        chk("mixed_y", y, -2);
        x = pack(-8, 0, 0, 0);
        run_sample(x, 0, 0, 0, 0, y);
        chk("msb_neg_y", y, -8);

        // Back-pressure with an ignored in_valid pulse
        bus.in_valid_80 = 1'b1;
        bus.x_in_80     = pack(1, 1, 1, 1);
        @(posedge clk_80); #1;
        bus.in_valid_80 = 1'b0;
        wait_valid(n);
        chk("bp_latency", n, DATA_W);
        for (int c = 0; c < 10; c++) begin
            bus.in_valid_80 = (c == 4);
            bus.x_in_80     = pack(-8, -8, -8, -8);
            @(posedge clk_80); #1;
            chk("bp_valid", bus.out_valid_80, 1);
            chk("bp_y", y_now(), 5);
            chk("bp_in_ready", bus.in_ready_80, 0);
        end
        bus.in_valid_80  = 1'b0;
        bus.out_ready_80 = 1'b1;
        @(posedge clk_80); #1;
        bus.out_ready_80 = 1'b0;
        chk("bp_release_idle", bus.in_ready_80, 1);
        chk("bp_release_busy", bus.busy_80, 0);
        chk("bp_release_valid", bus.out_valid_80, 0);

        // LUT write attempted during RUN
        bus.in_valid_80 = 1'b1;
        bus.x_in_80     = pack(1, 1, 1, 1);
        @(posedge clk_80); #1;
        bus.in_valid_80 = 1'b0;
        bus.cfg_we_80   = 1'b1;
        bus.cfg_addr_80 = 4'd15;
        bus.cfg_data_80 = '0;
        @(posedge clk_80); #1;
        bus.cfg_we_80 = 1'b0;
        chk("run_cfg_err_pulse", bus.cfg_err_80, 1);
        @(posedge clk_80); #1;
        chk("run_cfg_err_clear", bus.cfg_err_80, 0);
        wait_valid(n);
        chk("run_cfg_latency", n, DATA_W - 2);
        chk("run_cfg_y", y_now(), 5);
        bus.out_ready_80 = 1'b1;
        @(posedge clk_80); #1;
        bus.out_ready_80 = 1'b0;
        run_sample(pack(1, 1, 1, 1), 0, 0, 0, 0, y);
        chk("run_cfg_later_y", y, 5);

        // Random LUT contents, samples, same-cycle writes and hold times
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 3)) begin
                a = $urandom_range(0, 15);
                d = int'($urandom_range(0, 63)) - 32;
                cfg_write(a, d);
            end
            x = 16'($urandom);
            a = $urandom_range(0, 15);
            d = int'($urandom_range(0, 63)) - 32;
            run_sample(x, ($urandom_range(0, 1) == 1), a, d, $urandom_range(0, 3), y);
        end

        // Restore the h LUT and cross-check the model against the plain inner product
        for (int aa = 0; aa < 16; aa++) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (aa[i]) d += h[i];
            cfg_write(aa, d);
        end
        for (int it = 0; it < 8; it++) begin
            x = 16'($urandom);
            run_sample(x, 0, 0, 0, 0, y);
            chk("inner_prod", y, inner_prod(x));
        end

        // Reset during the second RUN cycle
        bus.in_valid_80 = 1'b1;
        bus.x_in_80     = pack(1, 1, 1, 1);
        @(posedge clk_80); #1;
        bus.in_valid_80 = 1'b0;
        @(posedge clk_80); #1;
        rst_80 = 1'b1;
        @(posedge clk_80); #1;
        rst_80 = 1'b0;
        for (int i = 0; i < 16; i++) lut_m[i] = 0;
        #1;
        chk("midrst_in_ready", bus.in_ready_80, 1);
        chk("midrst_busy", bus.busy_80, 0);
        chk("midrst_y", y_now(), 0);
        n = 0;
        repeat (6) begin
            @(posedge clk_80); #1;
            if (bus.out_valid_80) n++;
        end
        chk("midrst_no_valid", n, 0);
        run_sample(pack(1, 1, 1, 1), 0, 0, 0, 0, y);
        chk("midrst_lut_cleared", y, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
